// File: rtl/prod_accum_if.sv
// Handshake bundle between the operand sequencer / multiplier side and the
// product accumulator: job control, product stream and completed-sum output.
interface prod_accum_if #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             clr;
  logic             prod_valid;
  logic [63:0]      prod;
  logic             prod_ready;
  logic             sum_valid;
  logic [ACC_W-1:0] sum;
  logic             sum_ready;
  logic             busy;
  logic             ovf;

  modport master (
    output start, len, clr, prod_valid, prod, sum_ready,
    input  prod_ready, sum_valid, sum, busy, ovf
  );

  modport slave (
    input  start, len, clr, prod_valid, prod, sum_ready,
    output prod_ready, sum_valid, sum, busy, ovf
  );
endinterface

// File: rtl/prod_accum.sv
// Sum-of-products accumulator: adds a programmed number of 64-bit unsigned
// products into an ACC_W-bit accumulator and holds the result until taken.
module prod_accum #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic          CLK,
  input  logic          rst_n,
  prod_accum_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_ovf;

  // One extra bit on top of the accumulator captures the carry-out for ovf.
  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_add;
  logic             w_last;

  assign w_prod_ext = (ACC_W + 1)'(bus.prod);
  assign w_add      = {1'b0, r_acc} + w_prod_ext;
  assign w_last     = (r_cnt == r_len - CNT_W'(1));

  // clr masks prod_ready combinationally so an aborting cycle never accepts.
  assign bus.prod_ready = (r_state == S_ACCUM) && !bus.clr;
  assign bus.sum_valid  = (r_state == S_DONE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.sum        = r_sum;
  assign bus.ovf        = r_ovf;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.clr) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len   <= bus.len;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= (bus.len == '0) ? S_DONE : S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (bus.prod_valid) begin
            r_acc <= w_add[ACC_W-1:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_add[ACC_W]) r_ovf <= 1'b1;
            if (w_last) begin
              r_sum   <= w_add[ACC_W-1:0];
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (bus.sum_ready) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: table-driven jobs scored through a
// queue of expected sums, plus hand sequences for overflow, abort and reset.
module tb_prod_accum;

  localparam int ACC_W = 72;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;

  prod_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
  prod_accum_if #(.ACC_W(64),    .CNT_W(CNT_W)) b64 ();

  prod_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  prod_accum #(.ACC_W(64), .CNT_W(CNT_W)) u_dut64 (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] len;
    logic [63:0]      prods [4];
    bit               gap;
    int               hold;
    logic [ACC_W-1:0] exp_sum;
  } vec_t;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed-sum handshake on the 72-bit DUT pops one entry.
  always @(negedge clk) begin
    if (rst_n && bus.sum_valid && bus.sum_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got sum 0x%0h expected no result", bus.sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_sum", bus.sum, e.sum);
        check("sb_ovf", bus.ovf, e.ovf);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    e.sum = v.exp_sum;
    e.ovf = 1'b0;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.len   = v.len;
    tick();
    bus.start = 1'b0;
    bus.len   = 8'hA5;
    for (int i = 0; i < int'(v.len); i++) begin
      if (v.gap) begin
        bus.prod_valid = 1'b0;
        tick();
      end
      bus.prod_valid = 1'b1;
      bus.prod       = v.prods[i];
      #1;
      check({tag, "_prod_ready"}, bus.prod_ready, 1'b1);
      check({tag, "_early_valid"}, bus.sum_valid, 1'b0);
      tick();
    end
    bus.prod_valid = 1'b0;
    check({tag, "_sum_valid"}, bus.sum_valid, 1'b1);
    check({tag, "_busy_done"}, bus.busy, 1'b1);
    for (int h = 0; h < v.hold; h++) begin
      bus.start = 1'b1;
      bus.len   = 8'd2;
      #1;
      check({tag, "_hold_valid"}, bus.sum_valid, 1'b1);
      check({tag, "_hold_sum"}, bus.sum, v.exp_sum);
      check({tag, "_hold_nordy"}, bus.prod_ready, 1'b0);
      tick();
    end
    bus.start     = 1'b0;
    bus.sum_ready = 1'b1;
    tick();
    bus.sum_ready = 1'b0;
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
    check({tag, "_idle_valid"}, bus.sum_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{len: 8'd1, prods: '{64'h6, 64'h0, 64'h0, 64'h0},
                gap: 1'b0, hold: 0, exp_sum: 72'h6};
    vecs[1] = '{len: 8'd3,
                prods: '{64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001,
                         64'hFFFFFFFE00000001, 64'h0},
                gap: 1'b0, hold: 0, exp_sum: 72'h02FFFFFFFA00000003};
    vecs[2] = '{len: 8'd4, prods: '{64'd1, 64'd2, 64'd3, 64'd4},
                gap: 1'b1, hold: 5, exp_sum: 72'd10};
    vecs[3] = '{len: 8'd0, prods: '{64'h0, 64'h0, 64'h0, 64'h0},
                gap: 1'b0, hold: 1, exp_sum: 72'h0};
    vecs[4] = '{len: 8'd2,
                prods: '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0},
                gap: 1'b0, hold: 0, exp_sum: 72'h01FFFFFFFFFFFFFFFE};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.clr = 1'b0; bus.prod_valid = 1'b0;
    bus.prod = '0; bus.sum_ready = 1'b0;
    b64.start = 1'b0; b64.len = '0; b64.clr = 1'b0; b64.prod_valid = 1'b0;
    b64.prod = '0; b64.sum_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_prod_ready", bus.prod_ready, 1'b0);
    check("rst_sum_valid", bus.sum_valid, 1'b0);
    check("rst_sum", bus.sum, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Overflow on the 64-bit accumulator variant.
    b64.start = 1'b1;
    b64.len   = 8'd2;
    tick();
    b64.start      = 1'b0;
    b64.prod_valid = 1'b1;
    b64.prod       = 64'hFFFFFFFE00000001;
    tick();
    tick();
    b64.prod_valid = 1'b0;
    check("ovf_valid", b64.sum_valid, 1'b1);
    check("ovf_sum", b64.sum, 64'hFFFFFFFC00000002);
    check("ovf_flag", b64.ovf, 1'b1);
    tick();
    check("ovf_sticky", b64.ovf, 1'b1);
    b64.sum_ready = 1'b1;
    tick();
    b64.sum_ready = 1'b0;
    check("ovf_idle", b64.busy, 1'b0);
    check("ovf_kept_idle", b64.ovf, 1'b1);
    b64.start = 1'b1;
    b64.len   = 8'd1;
    tick();
    b64.start = 1'b0;
    check("ovf_cleared_start", b64.ovf, 1'b0);
    b64.prod_valid = 1'b1;
    b64.prod       = 64'd9;
    tick();
    b64.prod_valid = 1'b0;
    check("ovf_next_sum", b64.sum, 64'd9);
    b64.sum_ready = 1'b1;
    tick();
    b64.sum_ready = 1'b0;

    // Abort after two of five products, with a product offered in the clr cycle.
    bus.start = 1'b1;
    bus.len   = 8'd5;
    tick();
    bus.start = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod       = 64'd3;
    tick();
    bus.prod       = 64'd4;
    tick();
    bus.prod = 64'd100;
    bus.clr  = 1'b1;
    #1;
    check("clr_mask_ready", bus.prod_ready, 1'b0);
    tick();
    bus.clr        = 1'b0;
    bus.prod_valid = 1'b0;
    check("clr_busy", bus.busy, 1'b0);
    check("clr_sum", bus.sum, '0);
    check("clr_ovf", bus.ovf, 1'b0);
    vecs[0].prods[0] = 64'd7;
    vecs[0].exp_sum  = 72'd7;
    run_vec(vecs[0], "after_clr");
    tick();

    // Asynchronous reset between clock edges in the middle of a job.
    bus.start = 1'b1;
    bus.len   = 8'd3;
    tick();
    bus.start      = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod       = 64'd11;
    tick();
    bus.prod_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_prod_ready", bus.prod_ready, 1'b0);
    check("arst_sum_valid", bus.sum_valid, 1'b0);
    check("arst_sum", bus.sum, '0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_ovf", bus.ovf, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[1], "after_rst");
    tick();

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
# prod_accum

Downstream consumer of the 32x32 multiplier. Accumulates a programmed number of 64-bit unsigned products into a wide accumulator, forming a dot-product or sum-of-products term. Products arrive on a valid/ready handshake; the operand sequencer drives `prod_valid` one cycle after it issues an operand pair, matching the multiplier's one-cycle registered latency. The finished sum is held on a valid/ready output until it is taken.

## Interface
- `ACC_W`, default 72: accumulator and sum width. Must be ≥ 64.
- `CNT_W`, default 8: width of the term-count field. The maximum length is 2^CNT_W − 1 terms.
- `CLK`  input  1: single clock, rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: begins a new accumulation. Sampled only in IDLE.
- `len`  input  CNT_W: number of products to accumulate. Latched on an accepted `start`.
- `clr`  input  1: synchronous abort back to IDLE.
- `prod_valid`  input  1: `prod` is valid.
- `prod`  input  64: unsigned product from the multiplier.
- `prod_ready`  output  1: accumulator can accept a product.
- `sum_valid`  output  1: `sum` holds the completed result.
- `sum`  output  ACC_W: accumulated result.
- `sum_ready`  input  1: downstream takes `sum`.
- `busy`  output  1: high in ACCUM or DONE.
- `ovf`  output  1: sticky flag for a carry out of bit ACC_W−1 during the current accumulation.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - `start` = 1: latch `len`, clear the accumulator, clear `ovf`, reset the term counter to 0.
  - If `len` ≠ 0, go to ACCUM.
  - If `len` = 0, go to DONE with `sum` = 0.
  - `start` is ignored in every other state.
- **ACCUM**
  - `prod_ready` = 1.
  - On `prod_valid && prod_ready`: accumulator += zero-extended `prod`, counter += 1.
  - The add is unsigned modulo 2^ACC_W. A carry out of bit ACC_W−1 sets `ovf`, which stays set until the next accepted `start`, `clr` or reset.
  - When the accepted product is term number `len` (counter = `len` − 1 before the increment), register the final sum and go to DONE.
  - Cycles with `prod_valid` = 0 change nothing.
- **DONE**
  - `sum_valid` = 1 and `prod_ready` = 0.
  - `sum` and `ovf` stay stable until `sum_valid && sum_ready`, then go to IDLE.
- **clr** (synchronous, any state)
  - Next state is IDLE; accumulator, counter, `sum` and `ovf` all go to 0.
  - `clr` takes priority over `start`, over a product handshake and over a sum handshake in the same cycle.
  - A product presented in that cycle is not accepted: `prod_ready` is forced to 0 combinationally while `clr` = 1.
- **Reset** (asynchronous, any time, including mid-accumulation)
  - State goes to IDLE.
  - `prod_ready` = 0, `sum_valid` = 0, `sum` = 0, `busy` = 0, `ovf` = 0.
  - Accumulator and counter go to 0.
- `busy` = (state ≠ IDLE).

## Timing
- `prod_ready` and `sum_valid` are decoded from registered state only; there is no combinational path from `prod_valid` or `sum_ready` to them. The sole exception is the `clr` masking of `prod_ready`.
- `start` in IDLE at cycle t gives ACCUM (or DONE when `len` = 0) at t+1.
- Full throughput is one product per cycle. With `len` = N and `prod_valid` held high, products are accepted at t+1 … t+N and `sum_valid` rises at t+N+1.
- `len` = 0: `sum_valid` rises at t+1 with `sum` = 0.
- A sum handshake at cycle u gives IDLE at u+1, so the earliest next `start` is accepted at u+1. There is a minimum one-cycle gap between jobs.
- Changes on `len` outside the `start` cycle have no effect.

## Test plan
- **Single term:** `len` = 1, `prod` = 0x0000000000000006 → `sum_valid` 2 cycles after `start`, `sum` = 0x6, `ovf` = 0.
- **Full throughput:** `len` = 3, three back-to-back products of 0xFFFFFFFE00000001 (0xFFFFFFFF²) → `sum` = 0x02FFFFFFFA00000003, `sum_valid` at t+4.
- **Backpressure:** `len` = 4, products 1, 2, 3, 4 with `prod_valid` gaps, then `sum_ready` held low for 5 cycles → `sum` = 10, held stable with `sum_valid` = 1 throughout; IDLE the cycle after `sum_ready`; a `start` pulsed during DONE is ignored.
- **Zero length and overflow:**
  - `len` = 0 → `sum` = 0 at t+1.
  - With `ACC_W` = 64, `len` = 2, products 0xFFFFFFFE00000001 twice → `sum` = 0xFFFFFFFC00000002, `ovf` = 1.
- **Abort:**
  - `clr` asserted after 2 of 5 products, with `prod_valid` high in the same cycle → that product is not accepted; IDLE next cycle with `sum` = 0 and `ovf` = 0.
  - A new `len` = 1 job then returns only its own product.
- **Async reset:** `rst_n` driven low mid-ACCUM, between clock edges → all outputs are at their reset values immediately, without waiting for a clock edge; after release, a fresh job completes correctly.
